// File: rtl/addsub_sequencer.sv
// rtl/addsub_sequencer.sv - serial add/subtract, one 2-bit slice per cycle, LSB pair first
// Define ADDSUB_SEQ_OVF_EN to build the signed-overflow flag; otherwise ovf is tied to 0.
module addsub_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf
);

  localparam int STEPS = WIDTH / 2;
  localparam int STEPW = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [STEPW-1:0] LAST_STEP = STEPW'(STEPS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_next;

  logic [WIDTH-1:0] a_q, b_q;
  logic             sub_q;
  logic [STEPW-1:0] step;
  logic             carry;

  logic [1:0] a_pair, b_pair, sum_pair;
  logic       c_mid, c_slice;
  logic       last_step;

  // Subtract feeds the inverted B pair; the +1 arrives as carry-in of step 0.
  always_comb begin
    a_pair    = a_q[{step, 1'b0} +: 2];
    b_pair    = b_q[{step, 1'b0} +: 2] ^ {2{sub_q}};
    sum_pair  = '0;
    sum_pair[0] = a_pair[0] ^ b_pair[0] ^ carry;
    c_mid       = (a_pair[0] & b_pair[0]) | (a_pair[0] & carry) | (b_pair[0] & carry);
    sum_pair[1] = a_pair[1] ^ b_pair[1] ^ c_mid;
    c_slice     = (a_pair[1] & b_pair[1]) | (a_pair[1] & c_mid) | (b_pair[1] & c_mid);
    last_step   = (step == LAST_STEP);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last_step) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = start ? RUN : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q    <= '0;
      b_q    <= '0;
      sub_q  <= 1'b0;
      step   <= '0;
      carry  <= 1'b0;
      result <= '0;
      cout   <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            a_q    <= a;
            b_q    <= b;
            sub_q  <= sub;
            step   <= '0;
            carry  <= sub;
            result <= '0;
            cout   <= 1'b0;
          end
        end
        RUN: begin
          result[{step, 1'b0} +: 2] <= sum_pair;
          carry                     <= c_slice;
          if (last_step) begin
            step <= '0;
            cout <= c_slice;
          end else begin
            step <= step + 1'b1;
          end
        end
        default: begin
          step <= '0;
        end
      endcase
    end
  end

`ifdef ADDSUB_SEQ_OVF_EN
  // Signed overflow: carry into the MSB differs from carry out of it.
  logic ovf_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_q <= 1'b0;
    end else if (state != RUN) begin
      if (start) ovf_q <= 1'b0;
    end else if (last_step) begin
      ovf_q <= c_mid ^ c_slice;
    end
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

endmodule
